mbist_data_cmp: RTL and testbench

//   Read-side checker of the MBIST data path: the pattern selector supplies the expected write/read word;

---
 rtl/mbist_data_cmp.sv | 125 ++++++++++++
 tb/tb_mbist_data_cmp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mbist_data_cmp.sv
// rtl/mbist_data_cmp.sv - MBIST read-data comparator with first-fail capture and scan result chain
module mbist_data_cmp #(
  parameter int BIST_ADDR_WD    = 9,
  parameter int BIST_DATA_WD    = 32,
  parameter int BIST_RD_LAT     = 1,
  parameter int BIST_ERR_CNT_WD = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic                       cmp_clr,
  input  logic                       cmp_en,
  input  logic                       cmp_inv,
  input  logic [BIST_ADDR_WD-1:0]    cmp_addr,
  input  logic [BIST_DATA_WD-1:0]    pat_data,
  input  logic [BIST_DATA_WD-1:0]    mem_rdata,
  input  logic                       scan_shift,
  input  logic                       sdi,
  output logic                       cmp_err,
  output logic                       err_sticky,
  output logic [BIST_ADDR_WD-1:0]    fail_addr,
  output logic [BIST_ERR_CNT_WD-1:0] err_cnt,
  output logic                       sdo
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_FAIL} state_t;

  state_t                     state_q, state_d;
  logic                       vld_q  [BIST_RD_LAT];
  logic [BIST_ADDR_WD-1:0]    addr_q [BIST_RD_LAT];
  logic [BIST_DATA_WD-1:0]    exp_q  [BIST_RD_LAT];

  logic                       cmp_err_q, cmp_err_d;
  logic                       err_sticky_q, err_sticky_d;
  logic [BIST_ADDR_WD-1:0]    fail_addr_q, fail_addr_d;
  logic [BIST_ERR_CNT_WD-1:0] err_cnt_q, err_cnt_d;

  logic flush;
  logic mismatch;

  // Any cycle without run, or spent shifting, discards all in-flight reads.
  assign flush    = !run || scan_shift;
  assign mismatch = vld_q[BIST_RD_LAT-1] && !flush && !cmp_clr &&
                    (mem_rdata != exp_q[BIST_RD_LAT-1]);

  // Expected-data delay line matching the SRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BIST_RD_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else if (cmp_clr || flush) begin
      for (int i = 0; i < BIST_RD_LAT; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0]  <= cmp_en;
      addr_q[0] <= cmp_addr;
      exp_q[0]  <= cmp_inv ? ~pat_data : pat_data;
      for (int i = 1; i < BIST_RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      fail_addr_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmp_err_q    <= cmp_err_d;
      err_sticky_q <= err_sticky_d;
      fail_addr_q  <= fail_addr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Next state: clear beats shifting, shifting beats comparing; only the first fail is captured.
  always_comb begin
    state_d      = state_q;
    cmp_err_d    = 1'b0;
    err_sticky_d = err_sticky_q;
    fail_addr_d  = fail_addr_q;
    err_cnt_d    = err_cnt_q;
    if (cmp_clr) begin
      state_d      = S_IDLE;
      err_sticky_d = 1'b0;
      fail_addr_d  = '0;
      err_cnt_d    = '0;
    end else if (scan_shift) begin
      {err_sticky_d, err_cnt_d, fail_addr_d} =
        {sdi, err_sticky_q, err_cnt_q, fail_addr_q[BIST_ADDR_WD-1:1]};
    end else begin
      case (state_q)
        S_IDLE:  if (run) state_d = mismatch ? S_FAIL : S_CMP;
        S_CMP:   if (!run) state_d = S_IDLE;
                 else if (mismatch) state_d = S_FAIL;
        S_FAIL:  if (!run) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (mismatch) begin
        cmp_err_d = 1'b1;
        if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
        if (!err_sticky_q) begin
          err_sticky_d = 1'b1;
          fail_addr_d  = addr_q[BIST_RD_LAT-1];
        end
      end
    end
  end

  assign cmp_err    = cmp_err_q;
  assign err_sticky = err_sticky_q;
  assign fail_addr  = fail_addr_q;
  assign err_cnt    = err_cnt_q;
  assign sdo        = fail_addr_q[0];

endmodule

// File: tb/tb_mbist_data_cmp.sv
// tb/tb_mbist_data_cmp.sv - directed vector bench for mbist_data_cmp at read latencies 1, 2 and 3
module tb_mbist_data_cmp;

  logic        clk, rst_n, run, cmp_clr, cmp_en, cmp_inv, scan_shift, sdi;
  logic [8:0]  cmp_addr;
  logic [31:0] pat_data, mem_rdata;

  logic       err1, stk1, sdo1, err2, stk2, sdo2, err3, stk3, sdo3;
  logic [8:0] fa1, fa2, fa3;
  logic [3:0] cnt1, cnt2, cnt3;

  int checks = 0;
  int failures = 0;

  mbist_data_cmp #(.BIST_RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .run(run), .cmp_clr(cmp_clr), .cmp_en(cmp_en), .cmp_inv(cmp_inv),
    .cmp_addr(cmp_addr), .pat_data(pat_data), .mem_rdata(mem_rdata), .scan_shift(scan_shift),
    .sdi(sdi), .cmp_err(err1), .err_sticky(stk1), .fail_addr(fa1), .err_cnt(cnt1), .sdo(sdo1));
  mbist_data_cmp #(.BIST_RD_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .run(run), .cmp_clr(cmp_clr), .cmp_en(cmp_en), .cmp_inv(cmp_inv),
    .cmp_addr(cmp_addr), .pat_data(pat_data), .mem_rdata(mem_rdata), .scan_shift(scan_shift),
    .sdi(sdi), .cmp_err(err2), .err_sticky(stk2), .fail_addr(fa2), .err_cnt(cnt2), .sdo(sdo2));
  mbist_data_cmp #(.BIST_RD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .run(run), .cmp_clr(cmp_clr), .cmp_en(cmp_en), .cmp_inv(cmp_inv),
    .cmp_addr(cmp_addr), .pat_data(pat_data), .mem_rdata(mem_rdata), .scan_shift(scan_shift),
    .sdi(sdi), .cmp_err(err3), .err_sticky(stk3), .fail_addr(fa3), .err_cnt(cnt3), .sdo(sdo3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] pat;
    logic        inv;
    logic [31:0] rdata;
    logic        err;
    logic        sticky;
    logic [8:0]  fa;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one read at the next negedge; returns at the negedge where its cmp_err is visible.
  task automatic issue_read(input int lat, input logic [8:0] addr, input logic [31:0] pat,
                            input logic inv, input logic [31:0] rdata);
    @(negedge clk);
    cmp_en = 1'b1; cmp_addr = addr; pat_data = pat; cmp_inv = inv;
    repeat (lat) begin
      @(negedge clk);
      cmp_en = 1'b0; cmp_inv = 1'b0;
    end
    mem_rdata = rdata;
    @(negedge clk);
  endtask

  task automatic clear_all();
    @(negedge clk);
    cmp_clr = 1'b1;
    @(negedge clk);
    cmp_clr = 1'b0;
  endtask

  int pulses;
  logic [13:0] scan_exp;

  initial begin
    vecs[0] = '{9'h010, 32'h5555_5555, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 9'h000, 4'd0};
    vecs[1] = '{9'h023, 32'hAAAA_AAAA, 1'b0, 32'hAAAA_AAAB, 1'b1, 1'b1, 9'h023, 4'd1};
    vecs[2] = '{9'h040, 32'h0000_FFFF, 1'b1, 32'hFFFF_0000, 1'b0, 1'b1, 9'h023, 4'd1};
    vecs[3] = '{9'h1F0, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 9'h023, 4'd2};
    vecs[4] = '{9'h011, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 9'h023, 4'd2};
    vecs[5] = '{9'h012, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 9'h023, 4'd3};

    rst_n = 1'b0; run = 1'b0; cmp_clr = 1'b0; cmp_en = 1'b0; cmp_inv = 1'b0;
    scan_shift = 1'b0; sdi = 1'b0; cmp_addr = '0; pat_data = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_err", {31'd0, err1}, 32'd0);
    chk("reset_sticky", {31'd0, stk1}, 32'd0);
    chk("reset_fa", {23'd0, fa1}, 32'd0);
    chk("reset_cnt", {28'd0, cnt1}, 32'd0);
    chk("reset_sdo", {31'd0, sdo1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    chk("idle_err", {31'd0, err1}, 32'd0);

    // Single reads on the latency-1 instance; results accumulate across vectors.
    for (int v = 0; v < 6; v++) begin
      issue_read(1, vecs[v].addr, vecs[v].pat, vecs[v].inv, vecs[v].rdata);
      chk($sformatf("vec%0d_err", v), {31'd0, err1}, {31'd0, vecs[v].err});
      chk($sformatf("vec%0d_sticky", v), {31'd0, stk1}, {31'd0, vecs[v].sticky});
      chk($sformatf("vec%0d_fa", v), {23'd0, fa1}, {23'd0, vecs[v].fa});
      chk($sformatf("vec%0d_cnt", v), {28'd0, cnt1}, {28'd0, vecs[v].cnt});
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_end", v), {31'd0, err1}, 32'd0);
    end

    // 20 back-to-back mismatching reads: one pulse each, counter saturates, first address kept.
    clear_all();
    chk("clr_cnt", {28'd0, cnt1}, 32'd0);
    pulses = 0;
    pat_data = 32'h0; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (err1) pulses++;
      cmp_en = (i < 20);
      cmp_addr = 9'(5 + i);
    end
    chk("b2b_pulses", pulses, 32'd20);
    chk("sat_cnt", {28'd0, cnt1}, 32'hF);
    chk("sat_fa", {23'd0, fa1}, 32'h005);

    // Latency 3: three back-to-back reads, the middle one corrupted.
    clear_all();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (err3) pulses++;
      cmp_en = (i < 3);
      cmp_addr = 9'(i + 1);
      pat_data = 32'h1111_1111 * (i + 1);
      case (i)
        3:       mem_rdata = 32'h1111_1111;
        4:       mem_rdata = 32'h2222_2223;
        5:       mem_rdata = 32'h3333_3333;
        default: mem_rdata = 32'h0;
      endcase
    end
    chk("lat3_pulses", pulses, 32'd1);
    chk("lat3_fa", {23'd0, fa3}, 32'h002);
    chk("lat3_cnt", {28'd0, cnt3}, 32'd1);

    // Latency 2: run dropped one cycle after cmp_en discards the read, earlier results stay.
    clear_all();
    issue_read(2, 9'h077, 32'hF0F0_F0F0, 1'b0, 32'h0F0F_0F0F);
    chk("lat2_err", {31'd0, err2}, 32'd1);
    pulses = 0;
    @(negedge clk);
    cmp_en = 1'b1; cmp_addr = 9'h099; pat_data = 32'h0; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    cmp_en = 1'b0; run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (err2) pulses++;
    end
    chk("drop_pulses", pulses, 32'd0);
    chk("drop_cnt", {28'd0, cnt2}, 32'd1);
    chk("drop_fa", {23'd0, fa2}, 32'h077);
    chk("drop_sticky", {31'd0, stk2}, 32'd1);

    // cmp_clr in the same cycle as a mismatching compare: clear wins.
    @(negedge clk);
    cmp_en = 1'b1; cmp_addr = 9'h033; pat_data = 32'h0;
    @(negedge clk);
    cmp_en = 1'b0; mem_rdata = 32'h8000_0000; cmp_clr = 1'b1;
    @(negedge clk);
    cmp_clr = 1'b0;
    chk("clrwin_err", {31'd0, err1}, 32'd0);
    chk("clrwin_cnt", {28'd0, cnt1}, 32'd0);
    chk("clrwin_sticky", {31'd0, stk1}, 32'd0);

    // Scan out {sticky, cnt, fail_addr} LSB first, feeding it back in to restore.
    issue_read(1, 9'h0A5, 32'h0, 1'b0, 32'h1);
    issue_read(1, 9'h0B0, 32'h0, 1'b0, 32'h1);
    issue_read(1, 9'h0B1, 32'h0, 1'b0, 32'h1);
    scan_exp = {1'b1, 4'd3, 9'h0A5};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("sdo_bit%0d", i), {31'd0, sdo1}, {31'd0, scan_exp[i]});
      scan_shift = 1'b1;
      sdi = scan_exp[i];
    end
    @(negedge clk);
    scan_shift = 1'b0; sdi = 1'b0;
    chk("scan_restore_fa", {23'd0, fa1}, 32'h0A5);
    chk("scan_restore_cnt", {28'd0, cnt1}, 32'd3);
    chk("scan_restore_sticky", {31'd0, stk1}, 32'd1);

    // Asynchronous reset mid-test wipes every result immediately.
    #2 rst_n = 1'b0;
    #1;
    chk("async_fa", {23'd0, fa1}, 32'd0);
    chk("async_cnt", {28'd0, cnt1}, 32'd0);
    chk("async_sticky", {31'd0, stk1}, 32'd0);
    chk("async_sticky2", {31'd0, stk2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
